// File: rtl/sram_like_slave.sv
// SRAM-like bus slave bridging a req/addr_ok/data_ok master port onto a synchronous single-port RAM.
// Optional macro SRAM_LIKE_DELAY_EN stretches WAIT to DELAY+1 cycles with a 4-bit down-counter.
module sram_like_slave #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DELAY      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [31:0]           data_rdata,
  output logic                  resp_err,
  output logic                  ram_en,
  output logic [3:0]            ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [1:0]            dbg_state_o
);

  // Handshake: addr_ok is high exactly while IDLE; a request is accepted on any
  // cycle with data_req & data_addr_ok, and data_ok pulses once per accepted request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  if (DELAY > 15) begin : g_delay_range
    $error("DELAY must be in 0..15");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_addr_width_range
    $error("ADDR_WIDTH must be in 1..29");
  end

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned;
  logic [3:0]  byte_mask;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr_q[31:ADDR_WIDTH+2];

`ifdef SRAM_LIKE_DELAY_EN
  localparam logic [3:0] DelayLoad = 4'(DELAY);
  logic [3:0] cnt_q, cnt_d;
`endif

  always_comb begin
    misaligned = 1'b0;
    byte_mask  = 4'b0000;
    unique case (size_q)
      2'b00: byte_mask = 4'b0001 << addr_q[1:0];
      2'b01: begin
        misaligned = addr_q[0];
        byte_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        misaligned = |addr_q[1:0];
        byte_mask  = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
`ifdef SRAM_LIKE_DELAY_EN
    cnt_d        = cnt_q;
`endif
    data_addr_ok = (state_q == IDLE);
    data_data_ok = 1'b0;
    resp_err     = 1'b0;
    ram_en       = 1'b0;
    ram_wen      = 4'b0000;
    ram_addr     = '0;
    ram_wdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          wr_d    = data_wr;
          size_d  = data_size;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          state_d = MEM;
        end
      end
      MEM: begin
        ram_en    = 1'b1;
        ram_addr  = addr_q[ADDR_WIDTH+1:2];
        ram_wdata = wdata_q;
        // Misaligned writes still run the RAM cycle but with no lanes enabled.
        ram_wen   = (wr_q && !misaligned) ? byte_mask : 4'b0000;
        state_d   = WAIT;
`ifdef SRAM_LIKE_DELAY_EN
        cnt_d     = DelayLoad;
`endif
      end
      WAIT: begin
        // RAM output is valid in the first WAIT cycle, one cycle after ram_en.
`ifdef SRAM_LIKE_DELAY_EN
        if (!wr_q && cnt_q == DelayLoad) rdata_d = ram_rdata;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = RESP;
`else
        if (!wr_q) rdata_d = ram_rdata;
        state_d = RESP;
`endif
      end
      RESP: begin
        data_data_ok = 1'b1;
        resp_err     = misaligned;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_LIKE_DELAY_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_LIKE_DELAY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign data_rdata  = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave with a byte-lane synchronous RAM model.
module tb_sram_like_slave;

  localparam int unsigned AW = 16;
`ifdef SRAM_LIKE_DELAY_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk;
  logic          rst;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [31:0]   data_addr;
  logic [31:0]   data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [31:0]   data_rdata;
  logic          resp_err;
  logic          ram_en;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [1:0]    dbg_state;
  logic          ram_clr;

  int n_vec;
  int n_err;

  sram_like_slave #(.ADDR_WIDTH(AW), .DELAY(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .resp_err     (resp_err),
    .ram_en       (ram_en),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM model: read-before-write, output holds while disabled
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      ram_rdata <= 32'h0;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full transaction from an IDLE cycle, checked cycle by cycle
  task automatic xact(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] exp_wen,
                      input logic exp_err, input logic [31:0] exp_rdata);
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    check("hs_addr_ok", 32'(data_addr_ok), 32'd1);
    tick();
    data_req = 1'b0; data_wr = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
    check("mem_ram_en", 32'(ram_en), 32'd1);
    check("mem_ram_wen", 32'(ram_wen), 32'(exp_wen));
    check("mem_ram_addr", 32'(ram_addr), 32'(addr[AW+1:2]));
    check("mem_ram_wdata", ram_wdata, wdata);
    tick();
    for (int i = 0; i < EXTRA; i++) begin
      check("wait_early_ok", 32'(data_data_ok), 32'd0);
      tick();
    end
    check("wait_no_ok", 32'(data_data_ok), 32'd0);
    check("wait_ram_en", 32'(ram_en), 32'd0);
    tick();
    check("resp_ok", 32'(data_data_ok), 32'd1);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", data_rdata, exp_rdata);
    check("resp_addr_ok", 32'(data_addr_ok), 32'd0);
    tick();
    check("post_ok", 32'(data_data_ok), 32'd0);
    check("post_err", 32'(resp_err), 32'd0);
    check("post_addr_ok", 32'(data_addr_ok), 32'd1);
  endtask

  logic [31:0] b2b_addr [3];
  logic [1:0]  b2b_size [3];
  logic [31:0] b2b_exp  [3];

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; ram_clr = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = 32'h0; data_wdata = 32'h0;
    tick();
    tick();
    check("rst_addr_ok", 32'(data_addr_ok), 32'd1);
    check("rst_data_ok", 32'(data_data_ok), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0; ram_clr = 1'b0;
    tick();
    check("post_rst_addr_ok", 32'(data_addr_ok), 32'd1);
    check("post_rst_ram_en", 32'(ram_en), 32'd0);
    check("post_rst_rdata", data_rdata, 32'd0);

    // word write, read back, sub-word writes, misaligned writes
    xact(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0);
    xact(1'b0, 2'b10, 32'h10, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF);
    xact(1'b1, 2'b00, 32'h13, 32'h11111111, 4'b1000, 1'b0, 32'hDEADBEEF);
    xact(1'b1, 2'b01, 32'h12, 32'h22220000, 4'b1100, 1'b0, 32'hDEADBEEF);
    xact(1'b0, 2'b10, 32'h10, 32'h0, 4'b0000, 1'b0, 32'h2222BEEF);
    xact(1'b1, 2'b10, 32'h12, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'h2222BEEF);
    xact(1'b1, 2'b01, 32'h11, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'h2222BEEF);
    xact(1'b1, 2'b00, 32'h14, 32'h00000077, 4'b0001, 1'b0, 32'h2222BEEF);
    xact(1'b0, 2'b10, 32'h10, 32'h0, 4'b0000, 1'b0, 32'h2222BEEF);

    // back-to-back with req held high; junk writes offered while busy must be ignored
    b2b_addr[0] = 32'h10; b2b_size[0] = 2'b10; b2b_exp[0] = 32'h2222BEEF;
    b2b_addr[1] = 32'h20; b2b_size[1] = 2'b10; b2b_exp[1] = 32'h00000000;
    b2b_addr[2] = 32'h14; b2b_size[2] = 2'b00; b2b_exp[2] = 32'h00000077;
    data_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_wr = 1'b0; data_size = b2b_size[k]; data_addr = b2b_addr[k]; data_wdata = 32'h0;
      check("b2b_hs", 32'(data_addr_ok), 32'd1);
      for (int c = 1; c <= 3 + EXTRA; c++) begin
        tick();
        data_wr = 1'b1; data_size = 2'b10; data_addr = 32'h30; data_wdata = 32'h5A5A5A5A;
        check("b2b_busy", 32'(data_addr_ok), 32'd0);
        if (c == 1) begin
          check("b2b_wen", 32'(ram_wen), 32'd0);
          check("b2b_ram_addr", 32'(ram_addr), 32'(b2b_addr[k][AW+1:2]));
        end
        if (c == 3 + EXTRA) begin
          check("b2b_ok", 32'(data_data_ok), 32'd1);
          check("b2b_rdata", data_rdata, b2b_exp[k]);
        end else begin
          check("b2b_no_ok", 32'(data_data_ok), 32'd0);
        end
      end
      tick();
    end
    data_req = 1'b0; data_wr = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;

    // write request coinciding with reset must never reach the RAM
    rst = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10; data_addr = 32'h30; data_wdata = 32'hAAAAAAAA;
    tick();
    rst = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    check("abort_ram_en", 32'(ram_en), 32'd0);
    check("abort_rdata_clr", data_rdata, 32'd0);
    tick();
    check("abort_ram_en2", 32'(ram_en), 32'd0);

    // reset while in WAIT: no completion pulse
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h10;
    tick();
    data_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstwait_addr_ok", 32'(data_addr_ok), 32'd1);
    check("rstwait_rdata", data_rdata, 32'd0);
    for (int i = 0; i < 4 + EXTRA; i++) begin
      check("rstwait_no_ok", 32'(data_data_ok), 32'd0);
      tick();
    end

    xact(1'b0, 2'b10, 32'h30, 32'h0, 4'b0000, 1'b0, 32'h00000000);
    xact(1'b0, 2'b11, 32'h10, 32'h0, 4'b0000, 1'b1, 32'h2222BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
